// File: rtl/shift_add_multiplier_pkg.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier_pkg
//   Shared definitions for the MUL-path shift/add multiplier:
//   operand width, iteration count, counter width and FSM state encoding.
// ---------------------------------------------------------------------------
package shift_add_multiplier_pkg;

    localparam int unsigned OP_WIDTH    = 32;
    localparam int unsigned ITERATIONS  = 32;
    localparam int unsigned COUNT_WIDTH = 6;

    // Counter value seen during the final RUN iteration.
    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(ITERATIONS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    function automatic logic is_last_iter(input logic [COUNT_WIDTH-1:0] count);
        return count == LAST_COUNT;
    endfunction

endpackage

// File: rtl/shift_add_multiplier_adder.sv
// ---------------------------------------------------------------------------
// nbit_adder
//   Combinational N-bit ripple-carry adder (the shared datapath adder).
//   Ports:
//     A, B   in  N  addends
//     C_in   in  1  carry in
//     sum    out N  A + B + C_in (low N bits)
//     C_out  out 1  carry out of bit N-1
// ---------------------------------------------------------------------------
module nbit_adder
    import shift_add_multiplier_pkg::*;
#(
    parameter int unsigned N = OP_WIDTH
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         C_in,
    output logic [N-1:0] sum,
    output logic         C_out
);

    logic [N:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = C_in;
        for (int unsigned i = 0; i < N; i++) begin
            sum[i]       = A[i] ^ B[i] ^ carry[i];
            carry[i + 1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
        end
        C_out = carry[N];
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier
//   Multi-cycle unsigned 32x32->64 multiplier. One conditional add of the
//   multiplicand into the upper partial product per cycle, followed by a
//   65-bit right shift of {carry, acc, mq}. 33-cycle latency with a
//   start/done handshake.
//   Ports:
//     clk      in   1   clock, rising edge
//     reset    in   1   asynchronous, active-high
//     start    in   1   request, sampled in IDLE or DONE only
//     A        in   32  multiplicand (unsigned)
//     B        in   32  multiplier (unsigned)
//     busy     out  1   high while iterating
//     done     out  1   one-cycle pulse when product updates
//     product  out  64  registered result, held until next completion
// ---------------------------------------------------------------------------
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [OP_WIDTH-1:0]     A,
    input  logic [OP_WIDTH-1:0]     B,
    output logic                    busy,
    output logic                    done,
    output logic [2*OP_WIDTH-1:0]   product
);

    mul_state_t                 state;
    logic [OP_WIDTH-1:0]        mcand;
    logic [OP_WIDTH-1:0]        acc;
    logic [OP_WIDTH-1:0]        mq;
    logic [COUNT_WIDTH-1:0]     count;

    logic [OP_WIDTH-1:0]        add_sum;
    logic                       add_cout;
    logic [OP_WIDTH-1:0]        step_s;
    logic                       step_c;

    nbit_adder #(
        .N (OP_WIDTH)
    ) u_adder (
        .A     (acc),
        .B     (mcand),
        .C_in  (1'b0),
        .sum   (add_sum),
        .C_out (add_cout)
    );

    // Partial-product step: add the multiplicand only when the current
    // multiplier bit is set; the carry becomes the new MSB after the shift.
    always_comb begin
        step_c = 1'b0;
        step_s = acc;
        if (mq[0]) begin
            step_c = add_cout;
            step_s = add_sum;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            mcand   <= '0;
            acc     <= '0;
            mq      <= '0;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand <= A;
                        mq    <= B;
                        acc   <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end

                RUN: begin
                    done  <= 1'b0;
                    // {acc, mq} <= {step_c, step_s, mq} >> 1
                    acc   <= {step_c, step_s[OP_WIDTH-1:1]};
                    mq    <= {step_s[0], mq[OP_WIDTH-1:1]};
                    count <= count + 1'b1;
                    if (is_last_iter(count)) begin
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end

                DONE: begin
                    product <= {acc, mq};
                    done    <= 1'b1;
                    if (start) begin
                        mcand <= A;
                        mq    <= B;
                        acc   <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end

                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
module tb_shift_add_multiplier;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int          n_compared   = 0;
    int          n_mismatched = 0;
    int          cyc          = 0;
    int          n_done       = 0;
    int          done_cyc     = 0;
    int          done_cyc_prev = 0;
    logic [63:0] exp_q[$];

    shift_add_multiplier dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: every done pulse pops one expected product.
    always @(negedge clk) begin
        if (!reset && done) begin
            n_done++;
            done_cyc_prev = done_cyc;
            done_cyc      = cyc;
            if (exp_q.size() == 0)
                check("unexpected_done", 64'(done), 64'd0);
            else
                check("product", product, exp_q.pop_front());
        end
    end

    // Wait (bounded) for the next done after acceptance at cycle t0.
    task automatic wait_done(input int t0, input int base);
        bit seen;
        int k;
        seen = 1'b0;
        for (int i = 0; i < 45 && !seen; i++) begin
            @(posedge clk);
            #1;
            k = cyc - t0;
            if (k == 31) check("busy_last_run", 64'(busy), 64'd1);
            if (k == 32) begin
                check("busy_fall", 64'(busy), 64'd0);
                check("done_early", 64'(done), 64'd0);
            end
            #5;
            if (n_done != base) seen = 1'b1;
        end
        if (!seen)
            check("done_timeout", 64'd0, 64'd1);
        else
            check("latency", 64'(done_cyc - t0), 64'd33);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b);
        int t0;
        int base;
        logic [63:0] exp;
        exp   = 64'(a) * 64'(b);
        A     = a;
        B     = b;
        start = 1'b1;
        @(posedge clk);
        exp_q.push_back(exp);
        #1;
        start = 1'b0;
        t0    = cyc;
        base  = n_done;
        check("busy_rise", 64'(busy), 64'd1);
        wait_done(t0, base);
        repeat (2) @(posedge clk);
        #1;
        check("product_hold", product, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        int base;
        reset = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_product", product, 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_op(32'd3, 32'd5);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(32'd0, 32'h1234_5678);
        run_op(32'd1, 32'h8000_0000);
        for (int i = 0; i < 4; i++) run_op($urandom, $urandom);

        // start pulse mid-RUN must be ignored
        A = 32'd7; B = 32'd9; start = 1'b1;
        @(posedge clk);
        exp_q.push_back(64'd63);
        #1;
        start = 1'b0;
        t0    = cyc;
        base  = n_done;
        repeat (9) @(posedge clk);
        #1;
        A = 32'd2; B = 32'd2; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(t0, base);
        repeat (40) @(posedge clk);
        #1;
        check("busy_start_single_done", 64'(n_done - base), 64'd1);

        // back-to-back: start held through the DONE cycle
        A = 32'd4; B = 32'd6; start = 1'b1;
        @(posedge clk);
        exp_q.push_back(64'd24);
        #1;
        t0   = cyc;
        base = n_done;
        A    = 32'd10;
        B    = 32'd10;
        wait_done(t0, base);
        start = 1'b0;
        exp_q.push_back(64'd100);
        wait_done(t0 + 33, base + 1);
        check("b2b_gap", 64'(done_cyc - done_cyc_prev), 64'd33);

        // reset mid-operation aborts without a done
        A = 32'd123; B = 32'd456; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_product", product, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        base  = n_done;
        repeat (40) @(posedge clk);
        #1;
        check("abort_no_done", 64'(n_done - base), 64'd0);
        run_op(32'd6, 32'd7);

        repeat (3) @(posedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
